// File: rtl/lightsaber_settings_regs_if.sv
// Settings bus for the lightsaber controller: user requests in, registered settings out.
// Port names follow the controller's established signal names.
interface lightsaber_settings_regs_if #(
    parameter int COLOR_W = 8,
    parameter int CFG_W   = 2,
    parameter int IN_W    = 2,
    parameter int DEC_W   = 6
);
    logic [COLOR_W-1:0] Ri;
    logic [COLOR_W-1:0] Gi;
    logic [COLOR_W-1:0] Bi;
    logic [CFG_W-1:0]   configSet;
    logic [IN_W-1:0]    Ini;
    logic [DEC_W-1:0]   Deci;

    logic [COLOR_W-1:0] Ro;
    logic [COLOR_W-1:0] Go;
    logic [COLOR_W-1:0] Bo;
    logic [CFG_W-1:0]   configOut;
    logic [IN_W-1:0]    Ino;
    logic [DEC_W-1:0]   Deco;

    modport master (
        output Ri, Gi, Bi, configSet, Ini, Deci,
        input  Ro, Go, Bo, configOut, Ino, Deco
    );

    modport slave (
        input  Ri, Gi, Bi, configSet, Ini, Deci,
        output Ro, Go, Bo, configOut, Ino, Deco
    );
endinterface

// File: rtl/lightsaber_settings_regs.sv
// Registered settings store: colour, blade config and length, one DFF per bit with
// a synchronous active-high clear. Values pass through verbatim with 1-cycle latency.
module lightsaber_settings_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        q <= rst ? 1'b0 : d;
    end
endmodule

module lightsaber_settings_regs #(
    parameter int COLOR_W = 8,
    parameter int CFG_W   = 2,
    parameter int IN_W    = 2,
    parameter int DEC_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    lightsaber_settings_regs_if.slave bus
);
    localparam int TOT_W = 3 * COLOR_W + CFG_W + IN_W + DEC_W;

    logic [TOT_W-1:0] d;
    logic [TOT_W-1:0] q;

    // All fields share one flat bit vector so every bit gets an identical cell.
    assign d = {bus.Ri, bus.Gi, bus.Bi, bus.configSet, bus.Ini, bus.Deci};
    assign {bus.Ro, bus.Go, bus.Bo, bus.configOut, bus.Ino, bus.Deco} = q;

    for (genvar i = 0; i < TOT_W; i++) begin : g_bit
        lightsaber_settings_dff u_dff (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i])
        );
    end
endmodule

// File: tb/tb_lightsaber_settings_regs.sv
// Directed bench for lightsaber_settings_regs: vector table plus hold, mid-cycle and reset sequences.
module tb_lightsaber_settings_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;

    lightsaber_settings_regs_if bus ();

    lightsaber_settings_regs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] r, g, b;
        logic [1:0] cfg;
        logic [1:0] in;
        logic [5:0] dec;
        logic [33:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[9];

    function automatic logic [33:0] pack(input logic [7:0] r, g, b, input logic [1:0] c,
                                         input logic [1:0] n, input logic [5:0] dd);
        return {r, g, b, c, n, dd};
    endfunction

    function automatic vec_t mk(input logic rs, input logic [7:0] r, g, b, input logic [1:0] c,
                                input logic [1:0] n, input logic [5:0] dd, input logic [33:0] e);
        vec_t v;
        v.rst = rs; v.r = r; v.g = g; v.b = b; v.cfg = c; v.in = n; v.dec = dd; v.exp = e;
        return v;
    endfunction

    function automatic logic [33:0] outs();
        return {bus.Ro, bus.Go, bus.Bo, bus.configOut, bus.Ino, bus.Deco};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.Ri = v.r; bus.Gi = v.g; bus.Bi = v.b;
        bus.configSet = v.cfg; bus.Ini = v.in; bus.Deci = v.dec;
    endtask

    initial begin
        // rst, R, G, B, cfg, in, dec, expected outputs after the edge
        vecs[0] = mk(1, 8'hA5, 8'h3C, 8'hF0, 2'd1, 2'd3, 6'd45, 34'd0);
        vecs[1] = mk(1, 8'h5A, 8'hC3, 8'h0F, 2'd2, 2'd1, 6'd17, 34'd0);
        vecs[2] = mk(0, 8'd255, 8'd255, 8'd255, 2'd2, 2'd1, 6'd50,
                     pack(8'd255, 8'd255, 8'd255, 2'd2, 2'd1, 6'd50));
        vecs[3] = mk(0, 8'd128, 8'd0, 8'd128, 2'd3, 2'd2, 6'd33,
                     pack(8'd128, 8'd0, 8'd128, 2'd3, 2'd2, 6'd33));
        vecs[4] = mk(1, 8'd128, 8'd0, 8'd128, 2'd3, 2'd2, 6'd33, 34'd0);
        vecs[5] = mk(0, 8'd128, 8'd0, 8'd128, 2'd3, 2'd2, 6'd33,
                     pack(8'd128, 8'd0, 8'd128, 2'd3, 2'd2, 6'd33));
        vecs[6] = mk(0, 8'd0, 8'd0, 8'd1, 2'd0, 2'd3, 6'd63,
                     pack(8'd0, 8'd0, 8'd1, 2'd0, 2'd3, 6'd63));
        vecs[7] = mk(0, 8'd0, 8'd200, 8'd1, 2'd0, 2'd3, 6'd63,
                     pack(8'd0, 8'd200, 8'd1, 2'd0, 2'd3, 6'd63));
        vecs[8] = mk(0, 8'd7, 8'd8, 8'd9, 2'd1, 2'd0, 6'd60,
                     pack(8'd7, 8'd8, 8'd9, 2'd1, 2'd0, 6'd60));

        // Table pass: drive on the falling edge, compare 1 time unit after the rising edge.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Load 1.50 white and confirm it holds for 190 cycles.
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #1;
        check("load_white", outs(), vecs[2].exp);
        for (int c = 0; c < 190; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", c), outs(), vecs[2].exp);
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        @(negedge clk);
        drive(vecs[3]);
        #1;
        check("midcycle_unchanged", outs(), vecs[2].exp);
        @(posedge clk);
        #1;
        check("midcycle_updated", outs(), vecs[3].exp);

        // One-edge reset pulse with inputs held, then reload on the first edge after release.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pulse_clear", outs(), 34'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_hold", outs(), 34'd0);
        @(posedge clk);
        #1;
        check("rst_reload", outs(), vecs[3].exp);

        // Single-field toggle: only green moves.
        @(negedge clk);
        bus.Gi = 8'd200;
        @(posedge clk);
        #1;
        check("green_only", outs(), pack(8'd128, 8'd200, 8'd128, 2'd3, 2'd2, 6'd33));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
